// File: rtl/dma_master.sv
// rtl/dma_master.sv - single-channel block-copy bus master: read a word, write it, repeat len times
module dma_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [7:0]  len,
    input  logic        m_grant,
    input  logic [63:0] m_din,
    output logic        m_req,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [7:0]  len_q;
    logic [7:0]  idx;
    logic [7:0]  idx_inc;
    logic [63:0] data_buf;

    assign idx_inc = idx + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every bus-owning state stalls in place while the arbiter withholds the grant.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (len == 8'd0) ? S_DONE : S_REQ;
            S_REQ:  if (m_grant) state_nxt = S_RD;
            S_RD:   if (m_grant) state_nxt = S_CAP;
            S_CAP:  if (m_grant) state_nxt = S_WR;
            S_WR:   if (m_grant) state_nxt = (idx_inc == len_q) ? S_DONE : S_RD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q    <= 16'd0;
            dst_q    <= 16'd0;
            len_q    <= 8'd0;
            idx      <= 8'd0;
            data_buf <= 64'd0;
        end else begin
            if (state == S_IDLE && start && len != 8'd0) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= len;
                idx   <= 8'd0;
            end
            // Read data arrives one cycle after the address, so it is taken in CAP.
            if (state == S_CAP && m_grant) begin
                data_buf <= m_din;
            end
            if (state == S_WR && m_grant) begin
                idx <= idx_inc;
            end
        end
    end

    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = 16'd0;
        m_dout = data_buf;
        busy   = (state != S_IDLE);
        done   = 1'b0;
        case (state)
            S_REQ: m_req = 1'b1;
            S_RD, S_CAP: begin
                m_req  = 1'b1;
                m_addr = src_q + {8'd0, idx};
            end
            S_WR: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = dst_q + {8'd0, idx};
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_master.sv
// tb/tb_dma_master.sv - randomized bench for dma_master against an expected bus-cycle queue model
module tb_dma_master;

    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_CAP = 2'd2;
    localparam logic [1:0] K_WR  = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic        m_grant = 1'b0;
    logic [63:0] m_din = 64'd0;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic        busy;
    logic        done;

    dma_master dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .m_grant  (m_grant),
        .m_din    (m_din),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    rec_t        exp_q[$];
    rec_t        log_q[$];
    logic [15:0] salt = 16'h0;
    logic [63:0] last_buf = 64'd0;
    bit          chk_en = 1'b0;
    int          gmode = 0;
    bit          stall_req = 1'b0;
    int          stall_left = 0;
    bit          in_cap = 1'b0;
    int          done_cnt = 0;
    int          req_cycles = 0;
    bit          prev_v = 1'b0;
    logic        prev_req, prev_grant, prev_wr, prev_done;
    logic [15:0] prev_addr;
    logic [63:0] prev_dout;

    function automatic logic [63:0] pattern(input logic [15:0] a);
        return {salt, a, ~a, a ^ 16'h5A5A};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int n_writes();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].kind == K_WR) n++;
        return n;
    endfunction

    // Bus memory: fixed pattern, one-cycle read latency.
    always @(posedge clk) m_din <= pattern(m_addr);

    // Grant driver and per-cycle compare against the expected bus-cycle queue.
    always @(negedge clk) begin
        rec_t e;
        logic g;
        if (!chk_en) begin
            m_grant    = 1'b0;
            prev_v     = 1'b0;
            prev_done  = 1'b0;
            in_cap     = 1'b0;
            stall_left = 0;
        end else begin
            if (!m_req) begin
                check("idle_wr", m_wr, 0);
                check("idle_addr", m_addr, 0);
            end
            check("busy", busy, m_req | done);
            if (done) begin
                check("done_width", prev_done, 0);
                done_cnt++;
            end
            if (!m_wr) check("dout_hold", m_dout, last_buf);
            if (prev_v && prev_req && !prev_grant) begin
                check("stall_req", m_req, 1);
                check("stall_wr", m_wr, prev_wr);
                check("stall_addr", m_addr, prev_addr);
                check("stall_dout", m_dout, prev_dout);
            end
            if (m_req) req_cycles++;
            g = m_req && (gmode == 0 || $urandom_range(0, 99) < 70);
            if (m_req && stall_req && in_cap) begin
                stall_left = 4;
                stall_req  = 1'b0;
            end
            if (stall_left > 0) begin
                g = 1'b0;
                stall_left--;
            end
            m_grant = g;
            if (g) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_cycle actual=wr%0d@%h required=none at %0t", m_wr, m_addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_wr", m_wr, e.wr);
                    check("bus_addr", m_addr, e.addr);
                    if (e.wr) begin
                        check("bus_wdata", m_dout, e.data);
                        last_buf = e.data;
                    end
                    in_cap = (e.kind == K_RD);
                    log_q.push_back('{e.kind, m_wr, m_addr, m_dout});
                end
            end
            prev_v     = 1'b1;
            prev_req   = m_req;
            prev_grant = g;
            prev_wr    = m_wr;
            prev_addr  = m_addr;
            prev_dout  = m_dout;
            prev_done  = done;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_req"}, m_req, 0);
        check({tag, "_wr"}, m_wr, 0);
        check({tag, "_addr"}, m_addr, 0);
        check({tag, "_dout"}, m_dout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_transfer(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] l,
                                input int gm, input bit extra, input bit stall, input int rst_word,
                                output int cyc);
        logic [15:0] a;
        int done_before, req_before;
        bit seen, aborted;
        gmode = gm;
        log_q.delete();
        if (l != 8'd0) begin
            exp_q.push_back('{K_REQ, 1'b0, 16'h0, 64'h0});
            for (int i = 0; i < int'(l); i++) begin
                a = src + 16'(i);
                exp_q.push_back('{K_RD, 1'b0, a, 64'h0});
                exp_q.push_back('{K_CAP, 1'b0, a, 64'h0});
                exp_q.push_back('{K_WR, 1'b1, dst + 16'(i), pattern(a)});
            end
        end
        done_before = done_cnt;
        req_before  = req_cycles;
        seen = 1'b0;
        aborted = 1'b0;
        cyc = 0;
        @(negedge clk); #1;
        stall_req = stall;
        start = 1'b1;
        src_addr = src;
        dst_addr = dst;
        len = l;
        for (int k = 1; k <= 40 * int'(l) + 60 && !seen && !aborted; k++) begin
            @(negedge clk); #1;
            cyc = k;
            if (k == 1) start = 1'b0;
            if (extra && k == 4) begin
                start = 1'b1;
                src_addr = 16'($urandom);
                dst_addr = 16'($urandom);
                len = 8'($urandom_range(1, 255));
            end
            if (k == 5) start = 1'b0;
            if (done_cnt != done_before) seen = 1'b1;
            if (rst_word >= 0 && m_wr && n_writes() == rst_word + 1) begin
                #1;
                chk_en = 1'b0;
                reset_n = 1'b0;
                #1;
                reset_checks("async_rst");
                exp_q.delete();
                last_buf = 64'd0;
                repeat (2) @(negedge clk);
                #1;
                reset_n = 1'b1;
                chk_en = 1'b1;
                aborted = 1'b1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            repeat (6) begin @(negedge clk); #1; end
            check("rst_no_done", done_cnt - done_before, 0);
            check("rst_idle_req", m_req, 0);
            check("rst_idle_busy", busy, 0);
        end else begin
            check("done_seen", seen, 1);
            repeat (2) begin @(negedge clk); #1; end
            check("done_once", done_cnt - done_before, 1);
            check("busy_after", busy, 0);
            check("queue_empty", exp_q.size(), 0);
            if (l == 8'd0) check("len0_no_req", req_cycles - req_before, 0);
        end
        stall_req = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] l;
        reset_n = 1'b0;
        start = 1'b0;
        src_addr = 16'd0;
        dst_addr = 16'd0;
        len = 8'd0;
        #1;
        reset_checks("reset");
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Two-word copy with grant tied to request.
        salt = 16'h1234;
        run_transfer(16'h0000, 16'h7000, 8'd2, 0, 1'b0, 1'b0, -1, cyc);
        check("lat_len2", cyc, 8);
        check("log_size", log_q.size(), 7);
        if (log_q.size() >= 7) begin
            check("rd0_addr", log_q[1].addr, 16'h0000);
            check("wr0_addr", log_q[3].addr, 16'h7000);
            check("wr0_data", log_q[3].data, 64'h1234_0000_FFFF_5A5A);
            check("rd1_addr", log_q[4].addr, 16'h0001);
            check("wr1_addr", log_q[6].addr, 16'h7001);
            check("wr1_data", log_q[6].data, 64'h1234_0001_FFFE_5A5B);
        end

        // Zero-length copy completes without touching the bus.
        run_transfer(16'h1111, 16'h2222, 8'd0, 0, 1'b0, 1'b0, -1, cyc);
        check("lat_len0", cyc, 1);

        // Four-cycle grant withdrawal in CAP.
        salt = 16'h0BEE;
        run_transfer(16'h0300, 16'h0400, 8'd3, 0, 1'b0, 1'b1, -1, cyc);
        check("lat_stall", cyc, 15);

        // Reset during the write of the second of three words, then a clean transfer.
        run_transfer(16'h0500, 16'h0600, 8'd3, 0, 1'b0, 1'b0, 1, cyc);
        run_transfer(16'h0040, 16'h0900, 8'd3, 0, 1'b0, 1'b0, -1, cyc);
        check("lat_after_rst", cyc, 11);

        // start while busy is ignored.
        run_transfer(16'h0100, 16'h0200, 8'd4, 0, 1'b1, 1'b0, -1, cyc);
        check("lat_restart", cyc, 14);

        // Source address wrap.
        run_transfer(16'hFFFF, 16'h8000, 8'd2, 0, 1'b0, 1'b0, -1, cyc);
        if (log_q.size() >= 7) begin
            check("wrap_rd0", log_q[1].addr, 16'hFFFF);
            check("wrap_rd1", log_q[4].addr, 16'h0000);
        end else begin
            check("wrap_log_size", log_q.size(), 7);
        end

        for (int it = 0; it < 24; it++) begin
            salt = 16'($urandom);
            l = (it == 10) ? 8'd255 : 8'($urandom_range(0, 9));
            run_transfer(16'($urandom), 16'($urandom), l, int'($urandom_range(0, 1)),
                         (it % 3 == 0) && (l >= 8'd2), (it % 4 == 1), -1, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_master.md
DMA_MASTER -- requirements
Module: dma_master

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that launches a block copy; sampled in IDLE only.
REQ-004 SHALL have port src_addr, input, 16, first source word address; sampled with start.
REQ-005 SHALL have port dst_addr, input, 16, first destination word address; sampled with start.
REQ-006 SHALL have port len, input, 8, number of 64-bit words to copy (0..255); sampled with start.
REQ-007 SHALL have port m_grant, input, 1, bus grant from the bus arbiter.
REQ-008 SHALL have port m_din, input, 64, read data returned by the bus.
REQ-009 SHALL have port m_req, output, 1, bus request to the bus.
REQ-010 SHALL have port m_wr, output, 1, bus access type (1 = write, 0 = read).
REQ-011 SHALL have port m_addr, output, 16, bus word address.
REQ-012 SHALL have port m_dout, output, 64, bus write data.
REQ-013 SHALL have port busy, output, 1, high from the cycle after an accepted start until DONE is left.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RD, CAP, WR, DONE.
REQ-016 IDLE: start=1 with len!=0 SHALL latch src_addr, dst_addr, len, clear the word index, and go to REQ.
REQ-017 IDLE: start=1 with len=0 SHALL go directly to DONE without asserting m_req.
REQ-018 m_req SHALL be 1 in REQ, RD, CAP and WR, and 0 in IDLE and DONE.
REQ-019 REQ: SHALL wait for m_grant=1, then go to RD.
REQ-020 RD: SHALL drive m_wr=0 and m_addr=src+idx; if m_grant=1, go to CAP.
REQ-021 CAP: SHALL hold m_wr=0 and m_addr=src+idx; if m_grant=1, latch m_din into the 64-bit buffer (one-cycle read latency) and go to WR.
REQ-022 WR: SHALL drive m_wr=1, m_addr=dst+idx, m_dout=buffer; if m_grant=1, increment idx.
REQ-023 WR exit: after increment, SHALL go to DONE if idx equals the latched len, else to RD.
REQ-024 Throughput SHALL be 3 cycles per word while m_grant stays 1; m_req SHALL remain 1 between words.
REQ-025 If m_grant=0 in RD, CAP or WR, the FSM SHALL stall: state, idx, buffer and all bus outputs held, no latch, no increment.
REQ-026 Address arithmetic SHALL be 16-bit modulo; 0xFFFF+1 wraps to 0x0000.
REQ-027 DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 start SHALL be ignored in every state other than IDLE.
REQ-029 Outside WR, m_dout SHALL hold the buffer value; outside RD, CAP and WR, m_wr=0 and m_addr=0.
REQ-030 The block SHALL NOT check address decode validity; unmapped addresses are issued as-is.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE with m_req=0, m_wr=0, m_addr=0, m_dout=0, busy=0, done=0, idx=0, buffer=0, including mid-transfer; no done pulse SHALL follow.

Verification
REQ-032 src=0x0000, dst=0x7000, len=2, m_grant tied to m_req: bus shows RD 0x0000, CAP, WR 0x7000 with the data read, then RD 0x0001, CAP, WR 0x7001; done pulses once; busy high for the whole sequence.
REQ-033 len=0, start pulse: done pulses without m_req ever being asserted; busy returns to 0.
REQ-034 m_grant held 0 for 4 cycles during CAP: m_addr and m_wr held, buffer unchanged; the transfer resumes and completes with correct data.
REQ-035 reset_n pulsed low during WR of word 1 of 3: all outputs go to 0 asynchronously; no done pulse; a new start afterwards works normally.
REQ-036 start re-pulsed while busy with different addresses: ignored; the original transfer completes unchanged.
REQ-037 src=0xFFFF, len=2: read addresses are 0xFFFF then 0x0000.
